// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared op codes, FSM state encoding and helpers for the gate sweep sequencer.
package gate_sweep_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes 6 and 7 are reserved and must be rejected at start.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_golden.sv
// Golden reference for an N-input gate: reduction AND/OR/XOR and their inversions.
// Reserved op codes return 0; the sequencer never runs a sweep with them.
module gate_golden
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  // Select the expected gate output for the current vector.
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_XNOR: expected = ~^vec;
      OP_NAND: expected = ~&vec;
      OP_NOR:  expected = ~|vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Gate sweep sequencer: walks every input vector of a gate under test in
// ascending order, holds each for dwell+1 cycles, checks the gate output
// against the golden function on the last cycle of each hold and reports
// the pass/fail summary.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; results of the last sweep held
//   ST_DRIVE | driving dut_in, counting dwell, comparing on the last cycle
//   ST_DONE  | one cycle: done pulse, pass valid, dut_in back to 0
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op_sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_IN-1:0]    dut_in,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      err_cnt,
  output logic [N_IN-1:0]    fail_vec,
  output logic               bad_op
);

  localparam logic [N_IN-1:0]    LAST_VEC = '1;
  localparam logic [N_IN-1:0]    ONE_VEC  = N_IN'(1);
  localparam logic [DWELL_W-1:0] ONE_CNT  = DWELL_W'(1);

  state_t             state;
  logic [2:0]         op_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic               golden_bit;
  logic               mismatch;
  logic [N_IN:0]      err_next;

  gate_golden #(.N_IN(N_IN)) u_golden (
    .op       (op_q),
    .vec      (dut_in),
    .expected (golden_bit)
  );

  // Compare path is the only combinational use of dut_out; err_next folds in
  // the current compare so the final vector counts toward pass.
  assign mismatch = (dut_out != golden_bit);
  assign err_next = err_cnt + (N_IN + 1)'(mismatch);

  // Sequencer FSM with dwell counter, vector counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_AND;
      dwell_q  <= '0;
      cnt      <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
      bad_op   <= 1'b0;
    end else begin
      done   <= 1'b0;
      bad_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op_legal(op_sel)) begin
              op_q     <= op_sel;
              dwell_q  <= dwell;
              err_cnt  <= '0;
              fail_vec <= '0;
              pass     <= 1'b0;
              dut_in   <= '0;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= ST_DRIVE;
            end else begin
              bad_op <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt == dwell_q) begin
            cnt <= '0;
            if (mismatch) begin
              err_cnt <= err_next;
              if (err_cnt == '0) fail_vec <= dut_in;
            end
            if (dut_in == LAST_VEC) begin
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_next == '0);
              dut_in <= '0;
              state  <= ST_DONE;
            end else begin
              dut_in <= dut_in + ONE_VEC;
            end
          end else begin
            cnt <= cnt + ONE_CNT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a behavioural gate under test.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op_sel = 3'd0;
  logic [7:0] dwell = 8'd0;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, bad_op;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;

  // Gate under test wiring: 0 AND, 1 OR, 2 XOR, 3 XNOR
  logic [1:0] gate_kind = 2'd3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    dut_out = 1'b0;
    case (gate_kind)
      2'd0: dut_out = dut_in[1] & dut_in[0];
      2'd1: dut_out = dut_in[1] | dut_in[0];
      2'd2: dut_out = dut_in[1] ^ dut_in[0];
      2'd3: dut_out = ~(dut_in[1] ^ dut_in[0]);
      default: dut_out = 1'b0;
    endcase
  end

  gate_sweep_ctrl #(.N_IN(2), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sel   (op_sel),
    .dwell    (dwell),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec),
    .bad_op   (bad_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_dut_in"}, 32'(dut_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_fvec"}, 32'(fail_vec), 0);
    chk({tag, "_badop"}, 32'(bad_op), 0);
  endtask

  // One full sweep; checks vector order, hold length, sweep length and results.
  // repulse re-asserts start mid-sweep, which must be ignored.
  task automatic sweep(input string tag, input logic [2:0] op, input int dw,
                       input int exp_err, input int exp_fv, input int exp_pass,
                       input bit repulse);
    int total;
    total = 4 * (dw + 1);
    op_sel = op;
    dwell  = 8'(dw);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    // Mid-sweep input changes must not affect the running sweep.
    op_sel = 3'd5;
    dwell  = 8'd0;
    for (int c = 0; c < total; c++) begin
      if (repulse) start = (c == 1);
      chk({tag, "_vec"}, 32'(dut_in), 32'(c / (dw + 1)));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_done_early"}, 32'(done), 0);
      tick();
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_fvec"}, 32'(fail_vec), 32'(exp_fv));
    chk({tag, "_vec_end"}, 32'(dut_in), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({tag, "_no_rerun"}, 32'(busy), 0);
      chk({tag, "_no_2nd_done"}, 32'(done), 0);
    end
  endtask

  initial begin
    // 1: reset at t=0
    #2;
    chk_idle_zero("rst0");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle_zero("post_rst");

    // 2: XNOR gate, op XNOR, dwell 0
    gate_kind = 2'd3;
    sweep("xnor_ok", 3'd3, 0, 0, 0, 1, 1'b0);

    // 3: XOR gate checked as XNOR -> all four mismatch; then checked as XOR
    gate_kind = 2'd2;
    sweep("xnor_on_xor", 3'd3, 0, 4, 0, 0, 1'b0);
    sweep("xor_ok", 3'd2, 0, 0, 0, 1, 1'b0);

    // 4: AND gate, dwell 3 -> 16 busy cycles
    gate_kind = 2'd0;
    sweep("and_dw3", 3'd0, 3, 0, 0, 1, 1'b0);

    // OR gate at maximum dwell
    gate_kind = 2'd1;
    sweep("or_dwmax", 3'd1, 255, 0, 0, 1, 1'b0);

    // mid-idle reset clears pass
    #2 rst = 1'b1;
    #1;
    chk_idle_zero("rst_idle");
    #2 rst = 1'b0;
    tick();

    // NAND check on XNOR gate: mismatches at 01,10,11 -> first fail 01
    gate_kind = 2'd3;
    sweep("nand_on_xnor", 3'd4, 0, 3, 1, 0, 1'b0);

    // 6: reserved op codes rejected, results retained
    op_sel = 3'd6;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("bad6_pulse", 32'(bad_op), 1);
    chk("bad6_busy", 32'(busy), 0);
    chk("bad6_err", 32'(err_cnt), 3);
    chk("bad6_fvec", 32'(fail_vec), 1);
    chk("bad6_pass", 32'(pass), 0);
    tick();
    chk("bad6_pulse_end", 32'(bad_op), 0);
    chk("bad6_busy2", 32'(busy), 0);
    op_sel = 3'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("bad7_pulse", 32'(bad_op), 1);
    chk("bad7_err", 32'(err_cnt), 3);
    tick();
    chk("bad7_pulse_end", 32'(bad_op), 0);

    // 5: start re-pulsed mid-sweep is ignored
    gate_kind = 2'd3;
    sweep("repulse", 3'd3, 2, 0, 0, 1, 1'b1);

    // 5: reset while dut_in=10 aborts with results cleared
    gate_kind = 2'd2;
    op_sel = 3'd3;
    dwell  = 8'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("abort_vec_pre", 32'(dut_in), 2);
    chk("abort_err_pre", 32'(err_cnt), 2);
    #2 rst = 1'b1;
    #1;
    chk_idle_zero("abort");
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 0);
      chk("abort_no_busy", 32'(busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
